// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clock period meter.
package clk_meas_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TIMEOUT = 2'd2
    } meas_state_t;

    localparam logic [31:0] DEF_TIMEOUT_CYCLES = 32'd1_000_000;
    localparam int unsigned DEF_LOCK_COUNT     = 4;

    // Increment a match counter, holding at the lock target once reached
    function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
        return (value >= limit) ? limit : value + 4'd1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-stage synchronizer for an asynchronous slow clock, plus a delayed
// copy so that both rising and falling edges produce a one-cycle strobe.
module sync_edge_detect (
    input  logic clk_1M,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic edge_strobe
);

    logic s1_reg;
    logic s2_reg;
    logic p_reg;

    // Synchronizer chain and previous-value register
    always_ff @(posedge clk_1M or negedge reset) begin
        if (!reset) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
            p_reg  <= 1'b0;
        end else begin
            s1_reg <= din;
            s2_reg <= s1_reg;
            p_reg  <= s2_reg;
        end
    end

    assign level       = s2_reg;
    assign edge_strobe = s2_reg ^ p_reg;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the half-period of a slow clock in clk_1M cycles (reported as
// cycles minus one), tracks lock on repeated equal readings and flags a
// stalled input after TIMEOUT_CYCLES without an edge.
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned LOCK_COUNT     = DEF_LOCK_COUNT
) (
    input  logic        clk_1M,
    input  logic        reset,
    input  logic        clk_in,
    output logic [31:0] mult_out,
    output logic        valid,
    output logic        locked,
    output logic        timeout
);

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

    meas_state_t state_reg, state_next;
    logic [31:0] cnt_reg, cnt_next;
    logic [31:0] mult_reg, mult_next;
    logic [3:0]  match_reg, match_next;
    logic        valid_reg, valid_next;
    logic        locked_reg, locked_next;
    logic        timeout_reg, timeout_next;

    logic        edge_strobe;
    logic        sync_level_unused;

    sync_edge_detect u_sync (
        .clk_1M      (clk_1M),
        .reset       (reset),
        .din         (clk_in),
        .level       (sync_level_unused),
        .edge_strobe (edge_strobe)
    );

    // State, counter and output registers
    always_ff @(posedge clk_1M or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            mult_reg    <= '0;
            match_reg   <= '0;
            valid_reg   <= 1'b0;
            locked_reg  <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            mult_reg    <= mult_next;
            match_reg   <= match_next;
            valid_reg   <= valid_next;
            locked_reg  <= locked_next;
            timeout_reg <= timeout_next;
        end
    end

    // Next-state logic: measure intervals, update lock tracker, detect stalls
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        mult_next    = mult_reg;
        match_next   = match_reg;
        valid_next   = 1'b0;
        locked_next  = locked_reg;
        timeout_next = timeout_reg;

        case (state_reg)
            IDLE: begin
                // First edge only opens the measurement window
                if (edge_strobe) begin
                    state_next = MEASURE;
                    cnt_next   = '0;
                end
            end

            MEASURE: begin
                // An edge on the timeout cycle still counts as a measurement
                if (edge_strobe) begin
                    cnt_next   = '0;
                    mult_next  = cnt_reg;
                    valid_next = 1'b1;
                    if (cnt_reg == mult_reg) begin
                        match_next  = sat_inc(match_reg, LOCK_TARGET);
                        locked_next = (match_next == LOCK_TARGET);
                    end else begin
                        match_next  = '0;
                        locked_next = 1'b0;
                    end
                end else if (cnt_reg == TIMEOUT_CYCLES) begin
                    state_next   = TIMEOUT;
                    timeout_next = 1'b1;
                    locked_next  = 1'b0;
                    match_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end

            TIMEOUT: begin
                // The interval that ended the stall is incomplete; restart only
                if (edge_strobe) begin
                    state_next   = MEASURE;
                    cnt_next     = '0;
                    timeout_next = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mult_out = mult_reg;
    assign valid    = valid_reg;
    assign locked   = locked_reg;
    assign timeout  = timeout_reg;

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter. Stimulus is a list of toggle
// times; the reference model derives the expected valid/lock/timeout event
// stream from the gaps between toggles.
module tb_clk_period_meter;

    localparam int T_A   = 1_000_000;
    localparam int T_B   = 100;
    localparam int LOCKN = 4;

    localparam logic [1:0] K_VALID = 2'd0;
    localparam logic [1:0] K_LOCK  = 2'd1;
    localparam logic [1:0] K_TO    = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cyc;
        logic [31:0] val;
    } ev_t;

    logic        clk_1M;
    logic        reset;
    logic        clk_in_a, clk_in_b;
    logic [31:0] mult_a, mult_b;
    logic        valid_a, valid_b;
    logic        locked_a, locked_b;
    logic        timeout_a, timeout_b;

    logic [31:0] m_mult;
    logic        m_valid, m_locked, m_timeout;

    bit          sel;
    bit          log_en;
    int          cyc;
    int          n_run;
    int          n_fail;
    ev_t         log_q[$];
    ev_t         xlog[$];
    int          tq[$];
    logic        lk_prev, to_prev;
    logic [31:0] x_mult;
    bit          x_lk, x_to;

    clk_period_meter dut_a (
        .clk_1M   (clk_1M),
        .reset    (reset),
        .clk_in   (clk_in_a),
        .mult_out (mult_a),
        .valid    (valid_a),
        .locked   (locked_a),
        .timeout  (timeout_a)
    );

    clk_period_meter #(
        .TIMEOUT_CYCLES (32'd100),
        .LOCK_COUNT     (4)
    ) dut_b (
        .clk_1M   (clk_1M),
        .reset    (reset),
        .clk_in   (clk_in_b),
        .mult_out (mult_b),
        .valid    (valid_b),
        .locked   (locked_b),
        .timeout  (timeout_b)
    );

    assign m_mult    = sel ? mult_b    : mult_a;
    assign m_valid   = sel ? valid_b   : valid_a;
    assign m_locked  = sel ? locked_b  : locked_a;
    assign m_timeout = sel ? timeout_b : timeout_a;

    initial clk_1M = 1'b0;
    always #5 clk_1M = ~clk_1M;

    initial cyc = 0;
    always @(posedge clk_1M) cyc <= cyc + 1;

    function automatic ev_t mk_ev(input logic [1:0] kind, input int c, input logic [31:0] v);
        ev_t e;
        e.kind = kind;
        e.cyc  = 32'(c);
        e.val  = v;
        return e;
    endfunction

    // Monitor: log valid pulses and locked/timeout transitions of the selected DUT
    always @(negedge clk_1M) begin
        if (log_en) begin
            if (m_valid === 1'b1) begin
                log_q.push_back(mk_ev(K_VALID, cyc, m_mult));
                if (log_q.size() < 400)
                    $display("[TB] valid cycle=%0d mult_out=%0d locked=%0b", cyc, m_mult, m_locked);
            end
            if (m_locked !== lk_prev)
                log_q.push_back(mk_ev(K_LOCK, cyc, {31'd0, m_locked}));
            if (m_timeout !== to_prev)
                log_q.push_back(mk_ev(K_TO, cyc, {31'd0, m_timeout}));
        end
        lk_prev = m_locked;
        to_prev = m_timeout;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by time limit, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk_1M);
            #1;
        end
    endtask

    task automatic flip();
        if (sel) clk_in_b = ~clk_in_b;
        else     clk_in_a = ~clk_in_a;
        tq.push_back(cyc);
    endtask

    task automatic drive_gap(input int g);
        wait_cycles(g);
        flip();
    endtask

    task automatic do_reset(input logic level);
        log_en   = 1'b0;
        reset    = 1'b0;
        clk_in_a = 1'b0;
        clk_in_b = 1'b0;
        if (sel) clk_in_b = level;
        else     clk_in_a = level;
        wait_cycles(3);
        reset = 1'b1;
        tq.delete();
        log_q.delete();
        if (level) tq.push_back(cyc);
        log_en = 1'b1;
    endtask

    // Reference model: expected events from toggle times and the interval rules
    task automatic run_model(input int t_lim, input int e_last);
        int          prev;
        int          match;
        bit          armed, lk, new_lk, to_flag;
        logic [31:0] stale, m;
        prev = 0; match = 0; armed = 0; lk = 0; to_flag = 0; stale = '0;
        xlog.delete();
        foreach (tq[j]) begin
            if (armed && (tq[j] - prev) >= t_lim + 2) begin
                if (lk) xlog.push_back(mk_ev(K_LOCK, prev + t_lim + 4, 32'd0));
                xlog.push_back(mk_ev(K_TO, prev + t_lim + 4, 32'd1));
                xlog.push_back(mk_ev(K_TO, tq[j] + 3, 32'd0));
                lk    = 0;
                match = 0;
            end else if (armed) begin
                m = 32'(tq[j] - prev - 1);
                xlog.push_back(mk_ev(K_VALID, tq[j] + 3, m));
                if (m == stale) match = (match < LOCKN) ? match + 1 : LOCKN;
                else            match = 0;
                new_lk = (match == LOCKN);
                if (new_lk != lk) xlog.push_back(mk_ev(K_LOCK, tq[j] + 3, {31'd0, new_lk}));
                lk    = new_lk;
                stale = m;
            end
            prev  = tq[j];
            armed = 1;
        end
        if (armed && prev + t_lim + 4 <= e_last) begin
            if (lk) xlog.push_back(mk_ev(K_LOCK, prev + t_lim + 4, 32'd0));
            xlog.push_back(mk_ev(K_TO, prev + t_lim + 4, 32'd1));
            lk      = 0;
            to_flag = 1;
        end
        x_mult = stale;
        x_lk   = lk;
        x_to   = to_flag;
    endtask

    task automatic finish_window();
        @(negedge clk_1M);
        #1;
        log_en = 1'b0;
        run_model(sel ? T_B : T_A, cyc);
        $display("[TB] window closed: %0d toggles, %0d events observed, %0d expected", tq.size(), log_q.size(), xlog.size());
    endtask

    task automatic test_reset();
        sel = 0; log_en = 0;
        reset = 1'b0; clk_in_a = 1'b0; clk_in_b = 1'b0;
        wait_cycles(3);
        n_run++; if (mult_a !== 32'd0) begin n_fail++; $display("FAIL reset mult_out: got %0d expected 0", mult_a); end
        n_run++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset valid: got %b expected 0", valid_a); end
        n_run++; if (locked_a !== 1'b0) begin n_fail++; $display("FAIL reset locked: got %b expected 0", locked_a); end
        n_run++; if (timeout_a !== 1'b0) begin n_fail++; $display("FAIL reset timeout: got %b expected 0", timeout_a); end
        n_run++; if ({mult_b, valid_b, locked_b, timeout_b} !== 35'd0) begin n_fail++; $display("FAIL reset dut_b outputs: got %h expected 0", {mult_b, valid_b, locked_b, timeout_b}); end
        reset = 1'b1;
        wait_cycles(120);
        n_run++; if (timeout_b !== 1'b0) begin n_fail++; $display("FAIL reset idle_no_timeout: got %b expected 0", timeout_b); end
        n_run++; if (mult_b !== 32'd0) begin n_fail++; $display("FAIL reset idle_mult_out: got %0d expected 0", mult_b); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_mult4();
        sel = 0; do_reset(1'b0);
        flip();
        repeat (8) drive_gap(5);
        wait_cycles(6);
        finish_window();
        n_run++; if (log_q.size() != xlog.size()) begin n_fail++; $display("FAIL mult4 event_count: got %0d expected %0d", log_q.size(), xlog.size()); end
        for (int i = 0; i < xlog.size() && i < log_q.size(); i++) begin
            n_run++;
            if (log_q[i] !== xlog[i]) begin n_fail++; $display("FAIL mult4 event %0d: got kind=%0d cyc=%0d val=%0d expected kind=%0d cyc=%0d val=%0d", i, log_q[i].kind, log_q[i].cyc, log_q[i].val, xlog[i].kind, xlog[i].cyc, xlog[i].val); end
        end
        n_run++; if (m_mult !== x_mult) begin n_fail++; $display("FAIL mult4 final mult_out: got %0d expected %0d", m_mult, x_mult); end
        n_run++; if (m_locked !== x_lk) begin n_fail++; $display("FAIL mult4 final locked: got %b expected %b", m_locked, x_lk); end
        n_run++; if (m_timeout !== x_to) begin n_fail++; $display("FAIL mult4 final timeout: got %b expected %b", m_timeout, x_to); end
        n_run++; if (m_locked !== 1'b1) begin n_fail++; $display("FAIL mult4 locked_after_run: got %b expected 1", m_locked); end
    endtask

    task automatic test_sweep();
        sel = 0; do_reset(1'b0);
        flip();
        drive_gap(2);
        drive_gap(3);
        drive_gap(1000);
        drive_gap(50001);
        wait_cycles(6);
        finish_window();
        n_run++; if (log_q.size() != xlog.size()) begin n_fail++; $display("FAIL sweep event_count: got %0d expected %0d", log_q.size(), xlog.size()); end
        for (int i = 0; i < xlog.size() && i < log_q.size(); i++) begin
            n_run++;
            if (log_q[i] !== xlog[i]) begin n_fail++; $display("FAIL sweep event %0d: got kind=%0d cyc=%0d val=%0d expected kind=%0d cyc=%0d val=%0d", i, log_q[i].kind, log_q[i].cyc, log_q[i].val, xlog[i].kind, xlog[i].cyc, xlog[i].val); end
        end
        n_run++; if (m_mult !== x_mult) begin n_fail++; $display("FAIL sweep final mult_out: got %0d expected %0d", m_mult, x_mult); end
        n_run++; if (m_locked !== x_lk) begin n_fail++; $display("FAIL sweep final locked: got %b expected %b", m_locked, x_lk); end
        n_run++; if (m_timeout !== x_to) begin n_fail++; $display("FAIL sweep final timeout: got %b expected %b", m_timeout, x_to); end
    endtask

    task automatic test_random();
        int g;
        int reps;
        sel = 0; do_reset(1'(($urandom_range(0, 1))));
        flip();
        for (int r = 0; r < 14; r++) begin
            g    = int'($urandom_range(2, 25));
            reps = int'($urandom_range(1, 7));
            repeat (reps) drive_gap(g);
        end
        wait_cycles(6);
        finish_window();
        n_run++; if (log_q.size() != xlog.size()) begin n_fail++; $display("FAIL random event_count: got %0d expected %0d", log_q.size(), xlog.size()); end
        for (int i = 0; i < xlog.size() && i < log_q.size(); i++) begin
            n_run++;
            if (log_q[i] !== xlog[i]) begin n_fail++; $display("FAIL random event %0d: got kind=%0d cyc=%0d val=%0d expected kind=%0d cyc=%0d val=%0d", i, log_q[i].kind, log_q[i].cyc, log_q[i].val, xlog[i].kind, xlog[i].cyc, xlog[i].val); end
        end
        n_run++; if (m_mult !== x_mult) begin n_fail++; $display("FAIL random final mult_out: got %0d expected %0d", m_mult, x_mult); end
        n_run++; if (m_locked !== x_lk) begin n_fail++; $display("FAIL random final locked: got %b expected %b", m_locked, x_lk); end
        n_run++; if (m_timeout !== x_to) begin n_fail++; $display("FAIL random final timeout: got %b expected %b", m_timeout, x_to); end
    endtask

    task automatic test_period_change();
        sel = 0; do_reset(1'b0);
        flip();
        repeat (6) drive_gap(5);
        repeat (6) drive_gap(7);
        wait_cycles(6);
        finish_window();
        n_run++; if (log_q.size() != xlog.size()) begin n_fail++; $display("FAIL period_change event_count: got %0d expected %0d", log_q.size(), xlog.size()); end
        for (int i = 0; i < xlog.size() && i < log_q.size(); i++) begin
            n_run++;
            if (log_q[i] !== xlog[i]) begin n_fail++; $display("FAIL period_change event %0d: got kind=%0d cyc=%0d val=%0d expected kind=%0d cyc=%0d val=%0d", i, log_q[i].kind, log_q[i].cyc, log_q[i].val, xlog[i].kind, xlog[i].cyc, xlog[i].val); end
        end
        n_run++; if (m_mult !== x_mult) begin n_fail++; $display("FAIL period_change final mult_out: got %0d expected %0d", m_mult, x_mult); end
        n_run++; if (m_locked !== x_lk) begin n_fail++; $display("FAIL period_change final locked: got %b expected %b", m_locked, x_lk); end
        n_run++; if (m_timeout !== x_to) begin n_fail++; $display("FAIL period_change final timeout: got %b expected %b", m_timeout, x_to); end
    endtask

    task automatic test_timeout();
        sel = 1; do_reset(1'b0);
        flip();
        repeat (6) drive_gap(5);
        n_run++; if (m_locked !== 1'b1) begin n_fail++; $display("FAIL timeout pre_stall locked: got %b expected 1", m_locked); end
        wait_cycles(110);
        n_run++; if (m_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout stalled timeout: got %b expected 1", m_timeout); end
        n_run++; if (m_locked !== 1'b0) begin n_fail++; $display("FAIL timeout stalled locked: got %b expected 0", m_locked); end
        flip();
        drive_gap(5);
        drive_gap(5);
        wait_cycles(6);
        finish_window();
        n_run++; if (log_q.size() != xlog.size()) begin n_fail++; $display("FAIL timeout event_count: got %0d expected %0d", log_q.size(), xlog.size()); end
        for (int i = 0; i < xlog.size() && i < log_q.size(); i++) begin
            n_run++;
            if (log_q[i] !== xlog[i]) begin n_fail++; $display("FAIL timeout event %0d: got kind=%0d cyc=%0d val=%0d expected kind=%0d cyc=%0d val=%0d", i, log_q[i].kind, log_q[i].cyc, log_q[i].val, xlog[i].kind, xlog[i].cyc, xlog[i].val); end
        end
        n_run++; if (m_mult !== x_mult) begin n_fail++; $display("FAIL timeout final mult_out: got %0d expected %0d", m_mult, x_mult); end
        n_run++; if (m_locked !== x_lk) begin n_fail++; $display("FAIL timeout final locked: got %b expected %b", m_locked, x_lk); end
        n_run++; if (m_timeout !== x_to) begin n_fail++; $display("FAIL timeout final timeout: got %b expected %b", m_timeout, x_to); end
    endtask

    // Gap of TIMEOUT+1 puts the edge on the cycle cnt equals the limit;
    // a gap of TIMEOUT+2 is the first that stalls.
    task automatic test_timeout_boundary();
        sel = 1; do_reset(1'b0);
        flip();
        repeat (3) drive_gap(5);
        drive_gap(T_B + 1);
        drive_gap(T_B + 1);
        n_run++; if (m_timeout !== 1'b0) begin n_fail++; $display("FAIL boundary timeout_at_limit: got %b expected 0", m_timeout); end
        drive_gap(T_B + 2);
        drive_gap(5);
        wait_cycles(6);
        finish_window();
        n_run++; if (log_q.size() != xlog.size()) begin n_fail++; $display("FAIL boundary event_count: got %0d expected %0d", log_q.size(), xlog.size()); end
        for (int i = 0; i < xlog.size() && i < log_q.size(); i++) begin
            n_run++;
            if (log_q[i] !== xlog[i]) begin n_fail++; $display("FAIL boundary event %0d: got kind=%0d cyc=%0d val=%0d expected kind=%0d cyc=%0d val=%0d", i, log_q[i].kind, log_q[i].cyc, log_q[i].val, xlog[i].kind, xlog[i].cyc, xlog[i].val); end
        end
        n_run++; if (m_mult !== x_mult) begin n_fail++; $display("FAIL boundary final mult_out: got %0d expected %0d", m_mult, x_mult); end
        n_run++; if (m_locked !== x_lk) begin n_fail++; $display("FAIL boundary final locked: got %b expected %b", m_locked, x_lk); end
        n_run++; if (m_timeout !== x_to) begin n_fail++; $display("FAIL boundary final timeout: got %b expected %b", m_timeout, x_to); end
    endtask

    task automatic test_reset_mid();
        sel = 0; do_reset(1'b0);
        flip();
        repeat (6) drive_gap(5);
        wait_cycles(2);
        n_run++; if (m_locked !== 1'b1) begin n_fail++; $display("FAIL reset_mid pre_reset locked: got %b expected 1", m_locked); end
        #2;
        reset = 1'b0;
        #1;
        n_run++; if (mult_a !== 32'd0) begin n_fail++; $display("FAIL reset_mid mult_out: got %0d expected 0", mult_a); end
        n_run++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_mid valid: got %b expected 0", valid_a); end
        n_run++; if (locked_a !== 1'b0) begin n_fail++; $display("FAIL reset_mid locked: got %b expected 0", locked_a); end
        n_run++; if (timeout_a !== 1'b0) begin n_fail++; $display("FAIL reset_mid timeout: got %b expected 0", timeout_a); end
        log_en   = 1'b0;
        clk_in_a = 1'b1;
        wait_cycles(3);
        reset = 1'b1;
        tq.delete();
        log_q.delete();
        tq.push_back(cyc);
        log_en = 1'b1;
        drive_gap(5);
        drive_gap(5);
        wait_cycles(6);
        finish_window();
        n_run++; if (log_q.size() != xlog.size()) begin n_fail++; $display("FAIL reset_mid event_count: got %0d expected %0d", log_q.size(), xlog.size()); end
        for (int i = 0; i < xlog.size() && i < log_q.size(); i++) begin
            n_run++;
            if (log_q[i] !== xlog[i]) begin n_fail++; $display("FAIL reset_mid event %0d: got kind=%0d cyc=%0d val=%0d expected kind=%0d cyc=%0d val=%0d", i, log_q[i].kind, log_q[i].cyc, log_q[i].val, xlog[i].kind, xlog[i].cyc, xlog[i].val); end
        end
        n_run++; if (m_mult !== x_mult) begin n_fail++; $display("FAIL reset_mid final mult_out: got %0d expected %0d", m_mult, x_mult); end
        n_run++; if (m_locked !== x_lk) begin n_fail++; $display("FAIL reset_mid final locked: got %b expected %b", m_locked, x_lk); end
        n_run++; if (m_timeout !== x_to) begin n_fail++; $display("FAIL reset_mid final timeout: got %b expected %b", m_timeout, x_to); end
    endtask

    initial begin
        reset    = 1'b0;
        clk_in_a = 1'b0;
        clk_in_b = 1'b0;
        sel      = 0;
        log_en   = 0;
        n_run    = 0;
        n_fail   = 0;
        test_reset();
        test_mult4();
        test_sweep();
        test_random();
        test_period_change();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
